clk_div_n: RTL and testbench



---
 rtl/clk_div_pkg.sv | 15 +
 rtl/clk_div_n_if.sv | 23 ++
 rtl/clk_div_neg_retime.sv | 18 +
 rtl/clk_div_n.sv | 115 +++++++++++
 tb/tb_clk_div_n.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and the high-phase length helper for the clk_div_n divider.
package clk_div_pkg;

   localparam int CNT_W_DEF = 8;
   localparam int DIV_MIN   = 2;

   // Number of counter states that drive q_pos high for a period of n cycles.
   function automatic int unsigned hi_count(input int unsigned n, input bit odd50);
      if (odd50 && n[0])
         return (n - 1) >> 1;
      else
         return (n + 1) >> 1;
   endfunction

endpackage

// File: rtl/clk_div_n_if.sv
// Control/status bundle of clk_div_n: master = the divisor programmer, slave = the divider.
interface clk_div_n_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic [CNT_W-1:0] div_in;
   logic             div_ld;
   logic             div_ack;
   logic             div_err;
   logic [CNT_W-1:0] div_cur;
   logic             tick;
   logic             clk_out;

   modport master (
      output en, div_in, div_ld,
      input  div_ack, div_err, div_cur, tick, clk_out
   );

   modport slave (
      input  en, div_in, div_ld,
      output div_ack, div_err, div_cur, tick, clk_out
   );
endinterface

// File: rtl/clk_div_neg_retime.sv
// Falling-edge copy of q_pos used to stretch odd-N high phases by half a cycle.
module clk_div_neg_retime (
   input  logic clk,
   input  logic reset,
   input  logic q_pos_i,
   output logic q_neg_o
);
   logic q_neg_q;

   always_ff @(negedge clk) begin
      if (reset)
         q_neg_q <= 1'b0;
      else
         q_neg_q <= q_pos_i;
   end

   assign q_neg_o = q_neg_q;
endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with boundary-aligned divisor swap.
// Optional 50% duty for odd N via macro CLK_DIV_ODD_DUTY50_EN.
module clk_div_n
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DIV_DEFAULT = 3
) (
   input  logic        clk,
   input  logic        reset,
   clk_div_n_if.slave  bus
);
   localparam logic [CNT_W-1:0] N_MIN = CNT_W'(DIV_MIN);
   localparam logic [CNT_W-1:0] N_RST = CNT_W'(DIV_DEFAULT);
`ifdef CLK_DIV_ODD_DUTY50_EN
   localparam bit ODD50 = 1'b1;
`else
   localparam bit ODD50 = 1'b0;
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_cur_q, div_cur_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             q_pos_q, q_pos_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             ld_ok, wrap;
   logic [CNT_W-1:0] n_eff, hi;

   always_comb begin
      ld_ok      = bus.div_ld && (bus.div_in >= N_MIN);
      wrap       = (cnt_q == div_cur_q - 1'b1);
      err_d      = bus.div_ld && (bus.div_in < N_MIN);
      cnt_d      = cnt_q;
      div_cur_d  = div_cur_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      q_pos_d    = q_pos_q;
      tick_d     = 1'b0;
      ack_d      = 1'b0;
      n_eff      = div_cur_q;

      if (ld_ok) begin
         pend_d     = bus.div_in;
         pend_vld_d = 1'b1;
      end

      if (bus.en) begin
         if (wrap) begin
            // A load landing on the wrap cycle bypasses the pending register.
            if (ld_ok)
               n_eff = bus.div_in;
            else if (pend_vld_q)
               n_eff = pend_q;
            ack_d      = ld_ok || pend_vld_q;
            div_cur_d  = n_eff;
            pend_vld_d = 1'b0;
            cnt_d      = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      hi = CNT_W'(hi_count(32'(n_eff), ODD50));
      if (bus.en) begin
         q_pos_d = (cnt_d < hi);
         tick_d  = (cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= N_RST - 1'b1;
         div_cur_q  <= N_RST;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         q_pos_q    <= 1'b0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_cur_q  <= div_cur_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         q_pos_q    <= q_pos_d;
         tick_q     <= tick_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
      end
   end

   assign bus.tick    = tick_q;
   assign bus.div_ack = ack_q;
   assign bus.div_err = err_q;
   assign bus.div_cur = div_cur_q;

`ifdef CLK_DIV_ODD_DUTY50_EN
   logic q_neg;

   clk_div_neg_retime u_neg (
      .clk     (clk),
      .reset   (reset),
      .q_pos_i (q_pos_q),
      .q_neg_o (q_neg)
   );

   // Even N already has a balanced q_pos; the half-cycle stretch is for odd N only.
   assign bus.clk_out = q_pos_q | (q_neg & div_cur_q[0]);
`else
   assign bus.clk_out = q_pos_q;
`endif
endmodule

// File: tb/tb_clk_div_n.sv
// Directed self-checking bench for clk_div_n (default build and CLK_DIV_ODD_DUTY50_EN build).
module tb_clk_div_n;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   step_no = 0;

   clk_div_n_if #(.CNT_W(8)) bus ();

   clk_div_n #(.CNT_W(8), .DIV_DEFAULT(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step=%0d got=%0d exp=%0d", tag, step_no, got, exp);
      end
   endtask

   // Drive inputs, take one rising edge, then compare every output.
   task automatic step(input logic rst, input logic en, input logic ld, input logic [7:0] din,
                       input logic et, input logic ec, input logic ea, input logic ee,
                       input logic [7:0] ecur);
      reset      = rst;
      bus.en     = en;
      bus.div_ld = ld;
      bus.div_in = din;
      @(posedge clk);
      #1;
      step_no++;
      check("tick",    32'(bus.tick),    32'(et));
      check("clk_out", 32'(bus.clk_out), 32'(ec));
      check("div_ack", 32'(bus.div_ack), 32'(ea));
      check("div_err", 32'(bus.div_err), 32'(ee));
      check("div_cur", 32'(bus.div_cur), 32'(ecur));
   endtask

   task automatic wait_tick();
      int budget = 0;
      while (!bus.tick && budget < 40) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("tick_timeout", 32'(bus.tick), 32'd1);
   endtask

   // Samples clk_out every half cycle across one period starting at a tick.
   task automatic measure(input int n);
      wait_tick();
      check("half0", 32'(bus.clk_out), 32'd1);
      for (int k = 1; k < 2 * n; k++) begin
         if (k % 2 == 1) @(negedge clk);
         else            @(posedge clk);
         #1;
         check("half", 32'(bus.clk_out), (k < n) ? 32'd1 : 32'd0);
      end
      @(posedge clk);
      #1;
      check("period_tick", 32'(bus.tick), 32'd1);
   endtask

   task automatic load(input logic [7:0] n);
      int budget = 0;
      bus.div_ld = 1'b1;
      bus.div_in = n;
      @(posedge clk);
      #1;
      bus.div_ld = 1'b0;
      while (!bus.div_ack && budget < 40) begin
         @(posedge clk);
         #1;
         budget++;
      end
      check("ack_seen", 32'(bus.div_ack), 32'd1);
      check("ack_tick", 32'(bus.tick), 32'd1);
      check("cur_new",  32'(bus.div_cur), 32'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog step=%0d", step_no);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      bus.en     = 1'b0;
      bus.div_ld = 1'b0;
      bus.div_in = 8'd0;
`ifdef CLK_DIV_ODD_DUTY50_EN
      step(1, 0, 0, 0,  0, 0, 0, 0, 3);
      step(1, 0, 0, 0,  0, 0, 0, 0, 3);
      reset  = 1'b0;
      bus.en = 1'b1;
      measure(3);
      load(8'd5);
      measure(5);
      load(8'd6);
      measure(6);
`else
      // reset values; load ignored under reset
      step(1, 0, 0, 0,  0, 0, 0, 0, 3);
      step(1, 1, 1, 9,  0, 0, 0, 0, 3);
      // N=3: 1,1,0
      step(0, 1, 0, 0,  1, 1, 0, 0, 3);
      step(0, 1, 0, 0,  0, 1, 0, 0, 3);
      step(0, 1, 0, 0,  0, 0, 0, 0, 3);
      step(0, 1, 0, 0,  1, 1, 0, 0, 3);
      // load 4 mid-period, applied at wrap
      step(0, 1, 1, 4,  0, 1, 0, 0, 3);
      step(0, 1, 0, 0,  0, 0, 0, 0, 3);
      step(0, 1, 0, 0,  1, 1, 1, 0, 4);
      step(0, 1, 0, 0,  0, 1, 0, 0, 4);
      step(0, 1, 0, 0,  0, 0, 0, 0, 4);
      step(0, 1, 0, 0,  0, 0, 0, 0, 4);
      step(0, 1, 0, 0,  1, 1, 0, 0, 4);
      // illegal loads 1 and 0
      step(0, 1, 1, 1,  0, 1, 0, 1, 4);
      step(0, 1, 1, 0,  0, 0, 0, 1, 4);
      step(0, 1, 0, 0,  0, 0, 0, 0, 4);
      step(0, 1, 0, 0,  1, 1, 0, 0, 4);
      // 5 then 6 pending, 7 in the wrap cycle wins
      step(0, 1, 1, 5,  0, 1, 0, 0, 4);
      step(0, 1, 1, 6,  0, 0, 0, 0, 4);
      step(0, 1, 0, 0,  0, 0, 0, 0, 4);
      step(0, 1, 1, 7,  1, 1, 1, 0, 7);
      step(0, 1, 0, 0,  0, 1, 0, 0, 7);
      step(0, 1, 0, 0,  0, 1, 0, 0, 7);
      step(0, 1, 0, 0,  0, 1, 0, 0, 7);
      step(0, 1, 0, 0,  0, 0, 0, 0, 7);
      step(0, 1, 0, 0,  0, 0, 0, 0, 7);
      step(0, 1, 0, 0,  0, 0, 0, 0, 7);
      step(0, 1, 0, 0,  1, 1, 0, 0, 7);
      // freeze at cnt=1 for 5 cycles
      step(0, 1, 0, 0,  0, 1, 0, 0, 7);
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 0,  0, 1, 0, 0, 7);
      step(0, 1, 0, 0,  0, 1, 0, 0, 7);
      step(0, 1, 0, 0,  0, 1, 0, 0, 7);
      step(0, 1, 0, 0,  0, 0, 0, 0, 7);
      step(0, 1, 0, 0,  0, 0, 0, 0, 7);
      step(0, 1, 0, 0,  0, 0, 0, 0, 7);
      step(0, 1, 0, 0,  1, 1, 0, 0, 7);
      // reset mid-period discards pending 2
      step(0, 1, 1, 2,  0, 1, 0, 0, 7);
      step(1, 1, 0, 0,  0, 0, 0, 0, 3);
      step(0, 1, 0, 0,  1, 1, 0, 0, 3);
      step(0, 1, 0, 0,  0, 1, 0, 0, 3);
      step(0, 1, 0, 0,  0, 0, 0, 0, 3);
      step(0, 1, 0, 0,  1, 1, 0, 0, 3);
      // reload of the current divisor is still acknowledged
      step(0, 1, 1, 3,  0, 1, 0, 0, 3);
      step(0, 1, 0, 0,  0, 0, 0, 0, 3);
      step(0, 1, 0, 0,  1, 1, 1, 0, 3);
      step(0, 1, 0, 0,  0, 1, 0, 0, 3);
      // minimum divisor N=2
      step(0, 1, 1, 2,  0, 0, 0, 0, 3);
      step(0, 1, 0, 0,  1, 1, 1, 0, 2);
      step(0, 1, 0, 0,  0, 0, 0, 0, 2);
      step(0, 1, 0, 0,  1, 1, 0, 0, 2);
      step(0, 1, 0, 0,  0, 0, 0, 0, 2);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
